// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
// Optional timeout logic is enabled with the MEM_PORT_ARB_TIMEOUT_EN macro.
package mem_arb_pkg;

    localparam int DEF_AW      = 8;
    localparam int DEF_DW      = 8;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        XFER_CPU = 2'd1,
        XFER_DMA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin pick between the CPU and DMA requesters.
// A tie goes to whichever requester did not own the previous transfer.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dma_req,
    input  owner_t last_owner,
    output logic   valid,
    output owner_t winner
);

    // Select the winner; single requests win outright, ties alternate
    always_comb begin
        valid  = cpu_req | dma_req;
        winner = OWN_CPU;
        if (cpu_req && dma_req) begin
            winner = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
        end else if (dma_req) begin
            winner = OWN_DMA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single memory port of the multicycle CPU.
// The granted command is latched and held on the port until mem_ready.
// Define MEM_PORT_ARB_TIMEOUT_EN to add the wait counter and the err port.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_adr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_done,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
`ifdef MEM_PORT_ARB_TIMEOUT_EN
    output logic          err,
`endif
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    state_t        state_q;
    owner_t        last_owner_q;
    logic          cpu_gnt_q;
    logic          dma_gnt_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_adr_q;
    logic [DW-1:0] mem_wdata_q;

    logic          pick_valid;
    owner_t        pick_winner;
    logic          win_we;
    logic [AW-1:0] win_adr;
    logic [DW-1:0] win_wdata;
    logic          tmo_hit;
    logic          xfer_end;

    mem_arb_rr_pick u_pick (
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .last_owner (last_owner_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // Route the winning requester's command to the latch inputs
    always_comb begin
        win_we    = cpu_we;
        win_adr   = cpu_adr;
        win_wdata = cpu_wdata;
        if (pick_winner == OWN_DMA) begin
            win_we    = dma_we;
            win_adr   = dma_adr;
            win_wdata = dma_wdata;
        end
    end

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_q;

    // Count XFER cycles without mem_ready; IDLE clears it so entry starts at 0
    always_ff @(posedge clk) begin
        if (!reset || state_q == IDLE) begin
            wait_q <= '0;
        end else if (!mem_ready) begin
            wait_q <= wait_q + 1'b1;
        end
    end

    // The TIMEOUT-th waiting cycle aborts; a same-cycle mem_ready wins
    assign tmo_hit = (state_q != IDLE) && !mem_ready && (wait_q == CW'(TIMEOUT - 1));
    assign err     = tmo_hit;
`else
    // No timeout: XFER waits for mem_ready indefinitely; TIMEOUT kept for a uniform parameter list
    assign tmo_hit = (TIMEOUT < 0);
`endif

    assign xfer_end = mem_ready | tmo_hit;

    // Arbitration FSM with registered grant/port outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_owner_q <= OWN_DMA;
            cpu_gnt_q    <= 1'b0;
            dma_gnt_q    <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_adr_q    <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q      <= (pick_winner == OWN_CPU) ? XFER_CPU : XFER_DMA;
                        last_owner_q <= pick_winner;
                        cpu_gnt_q    <= (pick_winner == OWN_CPU);
                        dma_gnt_q    <= (pick_winner == OWN_DMA);
                        mem_en_q     <= 1'b1;
                        mem_we_q     <= win_we;
                        mem_adr_q    <= win_adr;
                        mem_wdata_q  <= win_wdata;
                    end
                end
                XFER_CPU, XFER_DMA: begin
                    if (xfer_end) begin
                        state_q   <= IDLE;
                        cpu_gnt_q <= 1'b0;
                        dma_gnt_q <= 1'b0;
                        mem_en_q  <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cpu_gnt_q <= 1'b0;
                    dma_gnt_q <= 1'b0;
                    mem_en_q  <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_gnt   = cpu_gnt_q;
    assign dma_gnt   = dma_gnt_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_adr   = mem_adr_q;
    assign mem_wdata = mem_wdata_q;

    // Completion goes to the owner only; read data passes through on mem_ready
    assign cpu_done  = cpu_gnt_q & xfer_end;
    assign dma_done  = dma_gnt_q & xfer_end;
    assign cpu_rdata = (cpu_gnt_q && mem_ready) ? mem_rdata : '0;
    assign dma_rdata = (dma_gnt_q && mem_ready) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of per-cycle vectors plus
// hand-written fairness and timeout sequences.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, dma_req, dma_we, mem_ready;
    logic [7:0] cpu_adr, cpu_wdata, dma_adr, dma_wdata, mem_rdata;
    logic       cpu_gnt, cpu_done, dma_gnt, dma_done, mem_en, mem_we;
    logic [7:0] cpu_rdata, dma_rdata, mem_adr, mem_wdata;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
    logic       err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(8), .DW(8), .TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_adr   (cpu_adr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_adr   (dma_adr),
        .dma_wdata (dma_wdata),
        .dma_gnt   (dma_gnt),
        .dma_done  (dma_done),
        .dma_rdata (dma_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        .err       (err),
`endif
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    typedef struct {
        logic        rst, cr, cw;
        logic [7:0]  ca, cd;
        logic        dr, dw;
        logic [7:0]  da, dd, mr;
        logic        rdy;
        logic [37:0] exp;
    } vec_t;

    vec_t tbl[$];

    // exp layout: cpu_gnt, cpu_done, cpu_rdata, dma_gnt, dma_done, dma_rdata, mem_en, mem_we, mem_adr, mem_wdata
    function automatic logic [37:0] ex(input logic cg, cdn, input logic [7:0] crd,
                                       input logic dg, ddn, input logic [7:0] drd,
                                       input logic en, we, input logic [7:0] ad, wd);
        return {cg, cdn, crd, dg, ddn, drd, en, we, ad, wd};
    endfunction

    function automatic void add(input logic rst, cr, cw, input logic [7:0] ca, cd,
                                input logic dr, dw, input logic [7:0] da, dd, mr,
                                input logic rdy, input logic [37:0] e);
        vec_t v;
        v.rst = rst; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.mr = mr; v.rdy = rdy; v.exp = e;
        tbl.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        reset = v.rst; cpu_req = v.cr; cpu_we = v.cw; cpu_adr = v.ca; cpu_wdata = v.cd;
        dma_req = v.dr; dma_we = v.dw; dma_adr = v.da; dma_wdata = v.dd;
        mem_rdata = v.mr; mem_ready = v.rdy;
    endtask

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [37:0] outs();
        return {cpu_gnt, cpu_done, cpu_rdata, dma_gnt, dma_done, dma_rdata,
                mem_en, mem_we, mem_adr, mem_wdata};
    endfunction

    initial begin
        vec_t v;
        logic [37:0] z;
        logic [3:0]  fexp;
        z = ex(0,0,8'h00, 0,0,8'h00, 0,0,8'h00,8'h00);

        // rst cr cw ca    cd     dr dw da    dd     mr     rdy expected
        add(0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 8'h00,0, z);
        add(1,1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 8'h00,0, z);
        add(1,1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 8'h00,0, ex(1,0,8'h00, 0,0,8'h00, 1,0,8'h10,8'h00));
        add(1,1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 8'h00,0, ex(1,0,8'h00, 0,0,8'h00, 1,0,8'h10,8'h00));
        add(1,1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 8'hA5,1, ex(1,1,8'hA5, 0,0,8'h00, 1,0,8'h10,8'h00));
        add(1,0,0,8'h10,8'h00, 0,0,8'h00,8'h00, 8'hFF,1, ex(0,0,8'h00, 0,0,8'h00, 0,0,8'h10,8'h00));
        add(1,0,0,8'h00,8'h00, 1,1,8'h20,8'h3C, 8'h00,0, ex(0,0,8'h00, 0,0,8'h00, 0,0,8'h10,8'h00));
        add(1,0,0,8'h00,8'h00, 1,1,8'h55,8'h77, 8'h00,0, ex(0,0,8'h00, 1,0,8'h00, 1,1,8'h20,8'h3C));
        add(1,0,0,8'h00,8'h00, 1,1,8'h55,8'h77, 8'h00,0, ex(0,0,8'h00, 1,0,8'h00, 1,1,8'h20,8'h3C));
        add(1,0,0,8'h00,8'h00, 1,1,8'h55,8'h77, 8'h99,1, ex(0,0,8'h00, 1,1,8'h99, 1,1,8'h20,8'h3C));
        add(1,0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 8'h00,0, ex(0,0,8'h00, 0,0,8'h00, 0,0,8'h20,8'h3C));
        add(1,1,0,8'h40,8'h00, 1,0,8'h41,8'h5A, 8'h00,0, ex(0,0,8'h00, 0,0,8'h00, 0,0,8'h20,8'h3C));
        add(1,1,0,8'h40,8'h00, 1,0,8'h41,8'h5A, 8'h11,1, ex(1,1,8'h11, 0,0,8'h00, 1,0,8'h40,8'h00));
        add(1,1,0,8'h40,8'h00, 1,0,8'h41,8'h5A, 8'h00,0, ex(0,0,8'h00, 0,0,8'h00, 0,0,8'h40,8'h00));
        add(1,1,0,8'h40,8'h00, 1,0,8'h41,8'h5A, 8'h22,1, ex(0,0,8'h00, 1,1,8'h22, 1,0,8'h41,8'h5A));
        add(1,0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 8'h00,0, ex(0,0,8'h00, 0,0,8'h00, 0,0,8'h41,8'h5A));
        add(1,1,1,8'h60,8'hEE, 0,0,8'h00,8'h00, 8'h00,0, ex(0,0,8'h00, 0,0,8'h00, 0,0,8'h41,8'h5A));
        add(1,1,1,8'h60,8'hEE, 0,0,8'h00,8'h00, 8'h00,0, ex(1,0,8'h00, 0,0,8'h00, 1,1,8'h60,8'hEE));
        add(0,1,1,8'h60,8'hEE, 0,0,8'h00,8'h00, 8'h00,0, ex(1,0,8'h00, 0,0,8'h00, 1,1,8'h60,8'hEE));
        add(1,1,0,8'h70,8'h00, 1,0,8'h71,8'h00, 8'h33,1, z);
        add(1,1,0,8'h70,8'h00, 1,0,8'h71,8'h00, 8'h00,0, ex(1,0,8'h00, 0,0,8'h00, 1,0,8'h70,8'h00));
        add(1,1,0,8'h70,8'h00, 1,0,8'h71,8'h00, 8'h44,1, ex(1,1,8'h44, 0,0,8'h00, 1,0,8'h70,8'h00));
        add(1,0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 8'h00,0, ex(0,0,8'h00, 0,0,8'h00, 0,0,8'h70,8'h00));

        v = tbl[0];
        drive(v);
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
`ifdef MEM_PORT_ARB_TIMEOUT_EN
            check($sformatf("vec%0d_err", i), {37'd0, err}, 38'd0);
`endif
        end

        // Fairness: reset, then both requesters held with a zero-wait memory
        @(negedge clk);
        reset = 1'b0; cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            @(negedge clk);
            reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 8'h80;
            dma_req = 1'b1; dma_we = 1'b0; dma_adr = 8'h90;
            mem_ready = 1'b1; mem_rdata = 8'h5C;
            #1;
            if (i % 2 == 0) fexp = 4'b0000;
            else if (((i - 1) / 2) % 2 == 0) fexp = 4'b1010;
            else fexp = 4'b0101;
            check($sformatf("fair%0d", i), {34'd0, cpu_gnt, dma_gnt, cpu_done, dma_done}, {34'd0, fexp});
        end

`ifdef MEM_PORT_ARB_TIMEOUT_EN
        // Timeout: never ready (err on 15th XFER cycle), then ready exactly on that cycle
        for (int unsigned pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            reset = 1'b0; cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0;
            for (int unsigned i = 0; i <= 16; i++) begin
                logic [10:0] texp;
                @(negedge clk);
                reset = 1'b1; cpu_req = (i < 16); cpu_we = 1'b0; cpu_adr = 8'hC0;
                dma_req = 1'b0; mem_rdata = (pass == 0) ? 8'hAB : 8'hCD;
                mem_ready = (pass == 1) && (i == 15);
                #1;
                if (i == 0 || i == 16) texp = {1'b0, 1'b0, 8'h00, 1'b0};
                else if (i < 15) texp = {1'b1, 1'b0, 8'h00, 1'b0};
                else if (pass == 0) texp = {1'b1, 1'b1, 8'h00, 1'b1};
                else texp = {1'b1, 1'b1, 8'hCD, 1'b0};
                check($sformatf("tmo%0d_%0d", pass, i), {27'd0, cpu_gnt, cpu_done, cpu_rdata, err},
                      {27'd0, texp});
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single 8-bit memory port of the multicycle CPU between the CPU (instruction fetch, load, store) and a DMA/loader master. The arbiter latches the granted requester's command and drives it onto the memory port. It holds the command until the memory acknowledges, then returns the acknowledgment and read data to the owner. It sits between the CPU top level (`adr`, `writedata`, `memwrite`) and the external memory.

## Interface
- `AW`, default 8: address width.
- `DW`, default 8: data width.
- `TIMEOUT`, default 15: maximum wait cycles for `mem_ready`; used only when the timeout feature is compiled in.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low; the block resets on the rising edge while `reset`=0.
- `cpu_req`  in  1: CPU requests an access.
- `cpu_we`  in  1: 1 = write, 0 = read.
- `cpu_adr`  in  AW: CPU address.
- `cpu_wdata`  in  DW: CPU write data.
- `cpu_gnt`  out  1: CPU owns the port.
- `cpu_done`  out  1: one-cycle completion pulse to the CPU.
- `cpu_rdata`  out  DW: read data, valid while `cpu_done`=1.
- `dma_req`, `dma_we`, `dma_adr`, `dma_wdata`, `dma_gnt`, `dma_done`, `dma_rdata`: same semantics for the DMA master.
- `mem_en`  out  1: access active.
- `mem_we`  out  1: write strobe.
- `mem_adr`  out  AW: latched address.
- `mem_wdata`  out  DW: latched write data.
- `mem_rdata`  in  DW: memory read data.
- `mem_ready`  in  1: memory completes the access this cycle.
- `err`  out  1: timeout pulse. Present only when the timeout feature is compiled in.

## Operation
- FSM states are IDLE, XFER_CPU and XFER_DMA, held in a state register. A `last_owner` flag holds the owner of the most recent transfer.
- IDLE:
  - Only one `req` high: go to that requester's XFER state.
  - Both high: grant the requester that is not `last_owner` (round-robin).
  - Neither high: stay in IDLE.
- On the grant edge, `we`, `adr` and `wdata` are latched from the winner into `mem_we`, `mem_adr` and `mem_wdata`. `last_owner` is updated to the winner.
- XFER_x:
  - `mem_en`=1 and `x_gnt`=1.
  - The latched fields stay constant; changes on the requester inputs are ignored.
  - When `mem_ready`=1: `x_done`=1 combinationally, `x_rdata`=`mem_rdata` (passthrough), and the next state is IDLE.
- The return to IDLE after every transfer is mandatory. It guarantees the owner sees `done` and can drop `req` before the next arbitration, so one stale `req` never produces a double grant.
- Requester rule: hold `req` until `done`, then drop it or re-raise it for a new access. Dropping `req` before a grant cancels the request cleanly. Dropping `req` after a grant does not abort the transfer.
- The `done` and `rdata` outputs of a non-owner are 0.
- Reset: state=IDLE and `last_owner`=DMA, so the CPU wins the first tie. All `gnt`, `done`, `mem_en`, `mem_we` and `err` outputs are 0; `mem_adr`, `mem_wdata`, `cpu_rdata` and `dma_rdata` are 0.
- Reset mid-transfer: the transfer is abandoned with no `done`, and `mem_en` is 0 in the cycle after the reset edge.

## Timing
- Request latency: `req` seen in IDLE at cycle N gives `gnt`=1 and `mem_en`=1 in cycle N+1.
- Completion: `mem_ready` in cycle N+1+L gives `done` in that same cycle and IDLE in cycle N+2+L.
- Throughput: minimum 2 cycles per transfer (zero-wait memory, L=0).
- Fairness: with both requesters held high, grants strictly alternate and neither waits more than one transfer.
- `mem_ready` outside XFER is ignored.

## Configuration
- Macro `MEM_PORT_ARB_TIMEOUT_EN`.
- Defined:
  - A wait counter clears on entry to XFER and increments each XFER cycle without `mem_ready`.
  - When the counter reaches `TIMEOUT`: the owner's `done`=1 with `rdata`=0, `err`=1 for that cycle, and the next state is IDLE.
  - A simultaneous `mem_ready` takes precedence: normal completion, `err`=0.
- Undefined: there is no counter and no `err` port, and XFER waits indefinitely.

## Structure
- Package `mem_arb_pkg` holds:
  - the state encoding (IDLE=2'd0, XFER_CPU=2'd1, XFER_DMA=2'd2);
  - the owner encoding (OWN_CPU=1'b0, OWN_DMA=1'b1);
  - default widths.
- One sub-module, `mem_arb_rr_pick`: combinational round-robin pick from `cpu_req`, `dma_req` and `last_owner`, giving a valid flag and the winner.

## Test plan
- After reset, `cpu_req`=1 read at `adr` 0x10, and memory returns 0xA5 with 2 wait cycles → `cpu_gnt` and `mem_en` high from cycle 1, `cpu_done` with `cpu_rdata`=0xA5 in cycle 3, IDLE in cycle 4.
- Both requesters raise `req` in the same cycle after reset → CPU is granted first, then DMA. Held continuously, grants alternate CPU, DMA, CPU, DMA over 4 transfers.
- DMA write 0x3C to 0x20 granted, then DMA changes `dma_adr` and `dma_wdata` mid-transfer → `mem_adr` stays 0x20 and `mem_wdata` stays 0x3C until `mem_ready`.
- `reset`=0 asserted during XFER_CPU → next cycle: all outputs 0, no `cpu_done`; the first tie after release goes to the CPU.
- `MEM_PORT_ARB_TIMEOUT_EN` with `TIMEOUT`=15 and `mem_ready` never asserted → `err`, `done` and `rdata`=0 exactly 15 XFER cycles after the grant, then IDLE.
- `MEM_PORT_ARB_TIMEOUT_EN` with `mem_ready` arriving on the counter's terminal cycle → normal completion with `err`=0.
